addsub_accum: RTL and testbench
===============================

# addsub_accum

Accumulator and sequencing stage wrapped around the 4-bit add/subtract unit. It accepts accumulator commands over a valid/ready handshake and drives the unit's A, B and mode inputs from registers. It captures the unit's Result and CarryOut, derives status flags, and returns the new accumulator value over a second valid/ready handshake. The add/subtract unit is instantiated beside this block, not inside it; the two connect through the `au_*` ports.

## Interface
- `WIDTH`, default 4: datapath width. Must equal the add/subtract unit width; only 4 is supported.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_op` input 2: 00 CLR, 01 LOAD, 10 ADD, 11 SUB.
- `cmd_data` input WIDTH: operand for LOAD/ADD/SUB; ignored for CLR.
- `au_a` output WIDTH: to adder A; registered.
- `au_b` output WIDTH: to adder B; registered.
- `au_mode` output 1: to adder mode (0 add, 1 subtract); registered.
- `au_result` input WIDTH: adder Result.
- `au_carry` input 1: adder CarryOut.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts response.
- `rsp_acc` output WIDTH: accumulator value.
- `rsp_carry` output 1: carry flag.
- `rsp_ovf` output 1: signed-overflow flag.
- `rsp_zero` output 1: zero flag.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE:** `cmd_ready`=1. On `cmd_valid`&&`cmd_ready`, latch the op and:
  - drive `au_a`<=acc, `au_b`<=`cmd_data`, `au_mode`<=(op==SUB);
  - go to ISSUE.
- **ISSUE:** single cycle; the adder is combinational. At the end of the cycle, update acc and flags per op, then go to RESP:
  - CLR: acc=0, carry=0, ovf=0, zero=1.
  - LOAD: acc=`au_b`, carry=0, ovf=0, zero=(`au_b`==0).
  - ADD: acc=`au_result`, carry=`au_carry`, ovf=(a[MSB]==b[MSB])&&(r[MSB]!=a[MSB]).
  - SUB: acc=`au_result`, carry=`au_carry` (1 = no borrow), ovf=(a[MSB]!=b[MSB])&&(r[MSB]!=a[MSB]).
  - ADD/SUB: zero=(`au_result`==0).
- **RESP:** `rsp_valid`=1. `rsp_*` are driven directly from acc and flag registers and stay stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
- All arithmetic is modulo 2^WIDTH; no saturation.
- `cmd_ready` is 0 in ISSUE and RESP. Commands presented then are held off, not dropped.
- `rsp_ready` is ignored outside RESP.

## Timing
- Command accepted at edge t. `au_*` valid during cycle t+1. `rsp_valid` rises in cycle t+2.
- Minimum command-to-command spacing is 3 cycles when `rsp_ready` is held high.
- Response back-pressure: each cycle RESP is held adds one cycle. No new command is accepted until the response handshake completes.
- Reset values while `rst_n`=0 at a rising edge:
  - state=IDLE, acc=0, carry=0, ovf=0, zero=1;
  - `au_a`=0, `au_b`=0, `au_mode`=0, `rsp_valid`=0;
  - `cmd_ready` is forced to 0 while `rst_n` is low.
- Reset mid-operation (ISSUE or RESP): the in-flight command is discarded and does not update acc. `rsp_valid` drops at that edge.
- `cmd_ready` is 1 in the first cycle after `rst_n` rises.

## Structure
- Shared package `addsub_pkg`:
  - `op_t` enum (CLR, LOAD, ADD, SUB) with the encodings above;
  - `state_t` enum (IDLE, ISSUE, RESP);
  - `ADDSUB_WIDTH`=4.
- One natural sub-module: `addsub_flags`, purely combinational. It takes op, a, b, result and carry, and returns next acc, carry, ovf and zero.
- The FSM, handshakes and registers live in `addsub_accum`.

## Test plan
- Reset, then idle → `cmd_ready`=1; `rsp_acc`=0, zero=1, carry=0, ovf=0; `rsp_valid`=0.
- LOAD 7, then ADD 1 → `au_a`=7, `au_b`=1, `au_mode`=0 in ISSUE; `rsp_acc`=8, carry=0, ovf=1, zero=0; `rsp_valid` exactly 2 cycles after accept.
- LOAD 3, then SUB 5 → `au_mode`=1; `rsp_acc`=0xE, carry=0 (borrow), ovf=0, zero=0. Then LOAD 5, SUB 5 → `rsp_acc`=0, carry=1, zero=1.
- LOAD 0xF, then ADD 1 → `rsp_acc`=0, carry=1, ovf=0, zero=1. Then CLR → `rsp_acc`=0, carry=0, zero=1.
- Hold `rsp_ready`=0 for 5 cycles in RESP with `cmd_valid` high → `rsp_*` stable, `cmd_ready`=0, no command lost. The pending command is accepted the cycle after the handshake.
- Pulse `rst_n`=0 during ISSUE of ADD 4 (acc=2) → acc=0 after reset, no response emitted, `cmd_ready`=1 the following cycle.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the accumulator stage that sequences the external
// 4-bit add/subtract unit.
//
// Contents:
//   ADDSUB_WIDTH : datapath width of the add/subtract unit (4 bits).
//   op_t         : accumulator command encoding (CLR, LOAD, ADD, SUB).
//   state_t      : sequencing FSM states (IDLE, ISSUE, RESP).
//   op_is_sub    : helper that selects the unit's subtract mode.
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 4;

    typedef enum logic [1:0] {
        CLR  = 2'b00,
        LOAD = 2'b01,
        ADD  = 2'b10,
        SUB  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    // The unit subtracts only for SUB; CLR and LOAD do not use its result,
    // so add mode is a harmless choice for them.
    function automatic logic op_is_sub(input op_t op);
        return (op == SUB);
    endfunction

endpackage

// File: rtl/addsub_flags.sv
// Combinational next-state computation for the accumulator and its flags.
//
// Ports:
//   op        in  2      latched command (op_t encoding)
//   a         in  WIDTH  operand A as presented to the add/subtract unit
//   b         in  WIDTH  operand B as presented to the add/subtract unit
//   result    in  WIDTH  unit Result for the current A/B/mode
//   carry     in  1      unit CarryOut (for subtract: 1 = no borrow)
//   next_acc  out WIDTH  new accumulator value
//   next_carry out 1     new carry flag
//   next_ovf  out 1      new signed-overflow flag
//   next_zero out 1      new zero flag
module addsub_flags
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    output logic [WIDTH-1:0] next_acc,
    output logic             next_carry,
    output logic             next_ovf,
    output logic             next_zero
);

    localparam int MSB = WIDTH - 1;

    op_t op_e;
    assign op_e = op_t'(op);

    // Running OR chains give "any bit set" for the result and for B, used
    // for the zero flag of ADD/SUB and LOAD respectively.
    logic [WIDTH:0] res_any;
    logic [WIDTH:0] b_any;

    assign res_any[0] = 1'b0;
    assign b_any[0]   = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_zero_chain
            assign res_any[gi+1] = res_any[gi] | result[gi];
            assign b_any[gi+1]   = b_any[gi] | b[gi];
        end
    endgenerate

    logic result_is_zero;
    logic b_is_zero;
    assign result_is_zero = ~res_any[WIDTH];
    assign b_is_zero      = ~b_any[WIDTH];

    // Two's-complement overflow: for addition the operands agree in sign
    // but the result does not; for subtraction the operands disagree in
    // sign and the result has left the sign of A.
    logic add_ovf;
    logic sub_ovf;
    assign add_ovf = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);

    always_comb begin
        // CLR values double as defaults.
        next_acc   = '0;
        next_carry = 1'b0;
        next_ovf   = 1'b0;
        next_zero  = 1'b1;
        unique case (op_e)
            CLR: begin
                next_acc   = '0;
                next_carry = 1'b0;
                next_ovf   = 1'b0;
                next_zero  = 1'b1;
            end
            LOAD: begin
                next_acc   = b;
                next_carry = 1'b0;
                next_ovf   = 1'b0;
                next_zero  = b_is_zero;
            end
            ADD: begin
                next_acc   = result;
                next_carry = carry;
                next_ovf   = add_ovf;
                next_zero  = result_is_zero;
            end
            SUB: begin
                next_acc   = result;
                next_carry = carry;
                next_ovf   = sub_ovf;
                next_zero  = result_is_zero;
            end
            default: begin
                next_acc   = '0;
                next_carry = 1'b0;
                next_ovf   = 1'b0;
                next_zero  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/addsub_accum.sv
// Accumulator and sequencing stage for an external 4-bit add/subtract unit.
// Commands arrive over a valid/ready handshake, the unit's operands and mode
// are driven from registers, the unit's Result/CarryOut are captured one
// cycle later, and the new accumulator plus flags are returned over a second
// valid/ready handshake.
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      synchronous active-low reset
//   cmd_valid  in  1      command present
//   cmd_ready  out 1      command can be accepted (IDLE and out of reset)
//   cmd_op     in  2      00 CLR, 01 LOAD, 10 ADD, 11 SUB
//   cmd_data   in  WIDTH  operand for LOAD/ADD/SUB
//   au_a       out WIDTH  unit operand A (registered)
//   au_b       out WIDTH  unit operand B (registered)
//   au_mode    out 1      unit mode, 0 add / 1 subtract (registered)
//   au_result  in  WIDTH  unit Result
//   au_carry   in  1      unit CarryOut
//   rsp_valid  out 1      response present
//   rsp_ready  in  1      consumer accepts response
//   rsp_acc    out WIDTH  accumulator value
//   rsp_carry  out 1      carry flag
//   rsp_ovf    out 1      signed-overflow flag
//   rsp_zero   out 1      zero flag
module addsub_accum
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_mode,
    input  logic [WIDTH-1:0] au_result,
    input  logic             au_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_carry,
    output logic             rsp_ovf,
    output logic             rsp_zero
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t           state_reg;
    state_t           state_next;

    op_t              op_reg;
    logic [WIDTH-1:0] au_a_reg;
    logic [WIDTH-1:0] au_b_reg;
    logic             au_mode_reg;

    logic [WIDTH-1:0] acc_reg;
    logic             carry_reg;
    logic             ovf_reg;
    logic             zero_reg;

    // Handshake strobes
    logic             cmd_fire;
    logic             rsp_fire;
    logic             issue_en;

    // Flag-unit outputs
    logic [WIDTH-1:0] acc_next;
    logic             carry_next;
    logic             ovf_next;
    logic             zero_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // The unit is combinational, so its result is ready by the
                // end of the single ISSUE cycle.
                state_next = RESP;
            end
            RESP: begin
                if (rsp_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and handshake strobes
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        issue_en  = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // Held low through reset so nothing is accepted on the
                // same edge that resets the FSM.
                cmd_ready = rst_n;
            end
            ISSUE: begin
                issue_en = 1'b1;
            end
            RESP: begin
                rsp_valid = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    assign cmd_fire = cmd_valid && cmd_ready;
    // rsp_ready has no effect unless a response is actually presented.
    assign rsp_fire = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------
    // Operand registers feeding the unit
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg      <= CLR;
            au_a_reg    <= '0;
            au_b_reg    <= '0;
            au_mode_reg <= 1'b0;
        end else if (cmd_fire) begin
            op_reg      <= op_t'(cmd_op);
            au_a_reg    <= acc_reg;
            au_b_reg    <= cmd_data;
            au_mode_reg <= op_is_sub(op_t'(cmd_op));
        end
    end

    assign au_a    = au_a_reg;
    assign au_b    = au_b_reg;
    assign au_mode = au_mode_reg;

    // ------------------------------------------------------------------
    // Accumulator and flags
    // ------------------------------------------------------------------
    addsub_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .op         (op_reg),
        .a          (au_a_reg),
        .b          (au_b_reg),
        .result     (au_result),
        .carry      (au_carry),
        .next_acc   (acc_next),
        .next_carry (carry_next),
        .next_ovf   (ovf_next),
        .next_zero  (zero_next)
    );

    // Reset wins over ISSUE, so a command caught mid-flight is dropped
    // without touching the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            zero_reg  <= 1'b1;
        end else if (issue_en) begin
            acc_reg   <= acc_next;
            carry_reg <= carry_next;
            ovf_reg   <= ovf_next;
            zero_reg  <= zero_next;
        end
    end

    // Response fields come straight from registers and therefore hold
    // steady for as long as the consumer stalls.
    assign rsp_acc   = acc_reg;
    assign rsp_carry = carry_reg;
    assign rsp_ovf   = ovf_reg;
    assign rsp_zero  = zero_reg;

endmodule

// File: tb/tb_addsub_accum.sv
module tb_addsub_accum;
    import addsub_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] au_a;
    logic [3:0] au_b;
    logic       au_mode;
    logic [3:0] au_result;
    logic       au_carry;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_acc;
    logic       rsp_carry;
    logic       rsp_ovf;
    logic       rsp_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] acc;
        logic       c;
        logic       v;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    addsub_accum #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .au_a      (au_a),
        .au_b      (au_b),
        .au_mode   (au_mode),
        .au_result (au_result),
        .au_carry  (au_carry),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_acc   (rsp_acc),
        .rsp_carry (rsp_carry),
        .rsp_ovf   (rsp_ovf),
        .rsp_zero  (rsp_zero)
    );

    // The add/subtract unit that sits beside the block: A + B, or
    // A + ~B + 1 for subtract, with CarryOut from the fifth bit.
    logic [4:0] au_sum;
    always_comb begin
        au_sum = 5'd0;
        if (au_mode) au_sum = {1'b0, au_a} + {1'b0, ~au_b} + 5'd1;
        else         au_sum = {1'b0, au_a} + {1'b0, au_b};
    end
    assign au_result = au_sum[3:0];
    assign au_carry  = au_sum[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (act=running req=finished)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: one line per completed response.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: actual acc=0x%0h c=%0b v=%0b z=%0b required no response",
                         rsp_acc, rsp_carry, rsp_ovf, rsp_zero);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rsp acc=0x%0h c=%0b v=%0b z=%0b (exp acc=0x%0h c=%0b v=%0b z=%0b)",
                         rsp_acc, rsp_carry, rsp_ovf, rsp_zero, mon_e.acc, mon_e.c, mon_e.v, mon_e.z);
                chk("rsp_acc",   8'(rsp_acc),   8'(mon_e.acc));
                chk("rsp_carry", 8'(rsp_carry), 8'(mon_e.c));
                chk("rsp_ovf",   8'(rsp_ovf),   8'(mon_e.v));
                chk("rsp_zero",  8'(rsp_zero),  8'(mon_e.z));
            end
        end
    end

    // Called just after a rising edge with cmd_valid already high; returns
    // just after the edge on which the command was accepted.
    task automatic wait_accept(input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept_timeout: actual cmd_ready=0 required 1 within 50 cycles", tag);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input logic [1:0] op, input logic [3:0] data,
                        input logic [3:0] prev, input logic [3:0] eacc,
                        input logic ec, input logic ev, input logic ez);
        exp_t e;
        e.acc = eacc; e.c = ec; e.v = ev; e.z = ez;
        exp_q.push_back(e);
        $display("cmd %s op=%0d data=0x%0h", tag, op, data);
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        wait_accept(tag);
        cmd_valid = 1'b0;
        @(negedge clk);  // ISSUE cycle
        chk({tag, "_au_a"},      8'(au_a),      8'(prev));
        chk({tag, "_au_b"},      8'(au_b),      8'(data));
        chk({tag, "_au_mode"},   8'(au_mode),   8'(op == 2'b11));
        chk({tag, "_issue_rv"},  8'(rsp_valid), 8'd0);
        chk({tag, "_issue_crd"}, 8'(cmd_ready), 8'd0);
        @(negedge clk);  // two cycles after accept
        chk({tag, "_rsp_valid"}, 8'(rsp_valid), 8'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;
        rsp_ready = 1'b1;

        @(negedge clk);
        chk("reset_cmd_ready_low", 8'(cmd_ready), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_cmd_ready", 8'(cmd_ready), 8'd1);
        chk("reset_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("reset_rsp_acc",   8'(rsp_acc),   8'd0);
        chk("reset_rsp_zero",  8'(rsp_zero),  8'd1);
        chk("reset_rsp_carry", 8'(rsp_carry), 8'd0);
        chk("reset_rsp_ovf",   8'(rsp_ovf),   8'd0);
        chk("reset_au_a",      8'(au_a),      8'd0);
        chk("reset_au_b",      8'(au_b),      8'd0);
        chk("reset_au_mode",   8'(au_mode),   8'd0);
        @(posedge clk);
        #1;

        //   tag            op    data  prev  acc   c     v     z
        send("load7",      LOAD, 4'h7, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0);
        send("add1",       ADD,  4'h1, 4'h7, 4'h8, 1'b0, 1'b1, 1'b0);
        send("load3",      LOAD, 4'h3, 4'h8, 4'h3, 1'b0, 1'b0, 1'b0);
        send("sub5",       SUB,  4'h5, 4'h3, 4'hE, 1'b0, 1'b0, 1'b0);
        send("load5",      LOAD, 4'h5, 4'hE, 4'h5, 1'b0, 1'b0, 1'b0);
        send("sub5_zero",  SUB,  4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1);
        send("loadF",      LOAD, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0);
        send("add1_wrap",  ADD,  4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b1);
        send("clr",        CLR,  4'hA, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        send("load6",      LOAD, 4'h6, 4'h0, 4'h6, 1'b0, 1'b0, 1'b0);
        send("add5_ovf",   ADD,  4'h5, 4'h6, 4'hB, 1'b0, 1'b1, 1'b0);
        send("load8",      LOAD, 4'h8, 4'hB, 4'h8, 1'b0, 1'b0, 1'b0);
        send("sub1_ovf",   SUB,  4'h1, 4'h8, 4'h7, 1'b1, 1'b1, 1'b0);
        send("load0",      LOAD, 4'h0, 4'h7, 4'h0, 1'b0, 1'b0, 1'b1);

        // Back-pressure: response held for 5 extra cycles with a command
        // waiting behind it.
        rsp_ready = 1'b0;
        send("load9_bp",   LOAD, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{acc: 4'hB, c: 1'b0, v: 1'b0, z: 1'b0});
        $display("cmd add2_pending op=%0d data=0x2", ADD);
        cmd_op    = ADD;
        cmd_data  = 4'h2;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 8'(rsp_valid), 8'd1);
            chk("bp_rsp_acc",   8'(rsp_acc),   8'h9);
            chk("bp_rsp_zero",  8'(rsp_zero),  8'd0);
            chk("bp_cmd_ready", 8'(cmd_ready), 8'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);  // response handshake
        #1;
        @(negedge clk);
        chk("bp_after_cmd_ready", 8'(cmd_ready), 8'd1);
        chk("bp_after_rsp_valid", 8'(rsp_valid), 8'd0);
        @(posedge clk);  // pending command accepted here
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("bp_pending_au_a",    8'(au_a),      8'h9);
        chk("bp_pending_au_b",    8'(au_b),      8'h2);
        chk("bp_pending_au_mode", 8'(au_mode),   8'd0);
        chk("bp_pending_rv",      8'(rsp_valid), 8'd0);
        @(negedge clk);
        chk("bp_pending_rsp_valid", 8'(rsp_valid), 8'd1);
        @(posedge clk);
        #1;

        // Reset during ISSUE of ADD 4 with acc=2: no response, acc cleared.
        send("load2",      LOAD, 4'h2, 4'hB, 4'h2, 1'b0, 1'b0, 1'b0);
        $display("cmd add4_aborted op=%0d data=0x4", ADD);
        cmd_op    = ADD;
        cmd_data  = 4'h4;
        cmd_valid = 1'b1;
        wait_accept("add4_abort");
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("abort_issue_au_a",    8'(au_a),      8'h2);
        chk("abort_cmd_ready_low", 8'(cmd_ready), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_cmd_ready", 8'(cmd_ready), 8'd1);
        chk("abort_rsp_valid", 8'(rsp_valid), 8'd0);
        chk("abort_rsp_acc",   8'(rsp_acc),   8'h0);
        chk("abort_rsp_zero",  8'(rsp_zero),  8'd1);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", 8'(rsp_valid), 8'd0);
        end
        @(posedge clk);
        #1;
        send("add3_post",  ADD,  4'h3, 4'h0, 4'h3, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
